// File: rtl/button_load_ctrl.sv
// Button/switch input stage for the digit latches: synchronize, debounce, capture the
// switch value on each accepted press, and serialize presses into single-cycle loads.
module button_load_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] button,
  input  logic [3:0] bcd,
  output logic       load_valid,
  output logic [1:0] load_idx,
  output logic [3:0] load_value,
  output logic [3:0] btn_level,
  output logic [7:0] guess_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       btn_meta_q, bs_q;
  logic [3:0]       val_meta_q, vs_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       level_q, level_d;
  logic [3:0]       level_dly_q;
  logic [3:0]       rise;
  logic [3:0]       val_q [4];
  logic [3:0]       val_d [4];
  logic [3:0]       pend_q, pend_d;
  logic             load_valid_q, load_valid_d;
  logic [1:0]       load_idx_q, load_idx_d;
  logic [3:0]       load_value_q, load_value_d;
  logic [7:0]       guess_count_q, guess_count_d;
  logic             pick_found;
  logic [1:0]       pick_idx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= '0;
      bs_q       <= '0;
      val_meta_q <= '0;
      vs_q       <= '0;
    end else begin
      btn_meta_q <= button;
      bs_q       <= btn_meta_q;
      val_meta_q <= bcd;
      vs_q       <= val_meta_q;
    end
  end

  // NOTE: every variable gets a default at the top of each always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (bs_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) level_d[i] = bs_q[i];
        else                     cnt_d[i]   = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // A press is seen one edge after the debounced level rises.
  assign rise = level_q & ~level_dly_q;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (pend_q[k] && !pick_found) begin
        pick_found = 1'b1;
        pick_idx   = 2'(k);
      end
    end
  end

  always_comb begin
    pend_d        = pend_q;
    val_d         = val_q;
    load_valid_d  = 1'b0;
    load_idx_d    = load_idx_q;
    load_value_d  = load_value_q;
    guess_count_d = guess_count_q;

    if (pick_found) begin
      load_valid_d     = 1'b1;
      load_idx_d       = pick_idx;
      load_value_d     = val_q[pick_idx];
      pend_d[pick_idx] = 1'b0;
      if (guess_count_q != 8'hFF) guess_count_d = guess_count_q + 8'd1;
    end

    // Capture is applied after the grant so a same-edge re-press keeps its pend bit.
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) begin
        val_d[i]  = vs_q;
        pend_d[i] = 1'b1;
      end
    end
  end

  // NOTE: the small captured-value array is reset along with the rest, so a
  // grant can never expose an unknown value after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
        val_q[i] <= '0;
      end
      level_q       <= '0;
      level_dly_q   <= '0;
      pend_q        <= '0;
      load_valid_q  <= 1'b0;
      load_idx_q    <= '0;
      load_value_q  <= '0;
      guess_count_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
        val_q[i] <= val_d[i];
      end
      level_q       <= level_d;
      level_dly_q   <= level_q;
      pend_q        <= pend_d;
      load_valid_q  <= load_valid_d;
      load_idx_q    <= load_idx_d;
      load_value_q  <= load_value_d;
      guess_count_q <= guess_count_d;
    end
  end

  assign load_valid  = load_valid_q;
  assign load_idx    = load_idx_q;
  assign load_value  = load_value_q;
  assign btn_level   = level_q;
  assign guess_count = guess_count_q;

endmodule

// File: tb/tb_button_load_ctrl.sv
// Directed self-checking bench for button_load_ctrl with a short debounce window (4 cycles).
module tb_button_load_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] button = 4'h0;
  logic [3:0] bcd = 4'h0;
  logic       load_valid;
  logic [1:0] load_idx;
  logic [3:0] load_value;
  logic [3:0] btn_level;
  logic [7:0] guess_count;

  int checks = 0;
  int errors = 0;

  button_load_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (button),
    .bcd        (bcd),
    .load_valid (load_valid),
    .load_idx   (load_idx),
    .load_value (load_value),
    .btn_level  (btn_level),
    .guess_count(guess_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int lv_seen;
    int bad;
    int total;

    // Reset with all buttons held: outputs clear, then four serialized loads.
    rst_n  = 1'b0;
    button = 4'hF;
    bcd    = 4'd7;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rst_load_valid", 32'(load_valid), 0);
    check("rst_load_idx", 32'(load_idx), 0);
    check("rst_load_value", 32'(load_value), 0);
    check("rst_btn_level", 32'(btn_level), 0);
    check("rst_guess_count", 32'(guess_count), 0);
    repeat (5) step();                       // edges 0..4
    check("rst_level_edge4", 32'(btn_level), 0);
    step();                                  // edge 5
    check("rst_level_edge5", 32'(btn_level), 32'hF);
    step();                                  // edge 6
    check("rst_lv_edge6", 32'(load_valid), 0);
    for (int k = 0; k < 4; k++) begin
      step();                                // edges 7..10
      check("rst_burst_lv", 32'(load_valid), 1);
      check("rst_burst_idx", 32'(load_idx), 32'(k));
      check("rst_burst_val", 32'(load_value), 7);
    end
    step();                                  // edge 11
    check("rst_burst_end", 32'(load_valid), 0);
    check("rst_guess4", 32'(guess_count), 4);

    button = 4'h0;
    do_reset();

    // Clean press on button 2 with bcd=9.
    bcd = 4'd9;
    repeat (3) step();
    button = 4'b0100;
    lv_seen = 0;
    for (int e = 0; e < 7; e++) begin        // edges 0..6
      step();
      lv_seen += int'(load_valid);
    end
    check("clean_no_early_lv", 32'(lv_seen), 0);
    step();                                  // edge 7
    check("clean_lv", 32'(load_valid), 1);
    check("clean_idx", 32'(load_idx), 2);
    check("clean_val", 32'(load_value), 9);
    step();                                  // edge 8
    check("clean_lv_one_cycle", 32'(load_valid), 0);
    check("clean_guess", 32'(guess_count), 1);
    check("clean_hold_idx", 32'(load_idx), 2);
    button = 4'h0;
    lv_seen = 0;
    repeat (20) begin
      step();
      lv_seen += int'(load_valid);
    end
    check("release_no_load", 32'(lv_seen), 0);
    check("release_level", 32'(btn_level), 0);
    check("release_guess", 32'(guess_count), 1);

    // Bounce: 3-cycle pulses on button 1 never qualify.
    bad = 0;
    repeat (5) begin
      button = 4'b0010;
      repeat (3) begin
        step();
        if (btn_level[1] || load_valid) bad++;
      end
      button = 4'b0000;
      repeat (3) begin
        step();
        if (btn_level[1] || load_valid) bad++;
      end
    end
    repeat (10) begin
      step();
      if (btn_level[1] || load_valid) bad++;
    end
    check("bounce_ignored", 32'(bad), 0);
    check("bounce_guess", 32'(guess_count), 1);

    // Simultaneous press on buttons 0 and 3.
    bcd = 4'd5;
    repeat (3) step();
    button = 4'b1001;
    lv_seen = 0;
    for (int e = 0; e < 7; e++) begin
      step();
      lv_seen += int'(load_valid);
    end
    check("simul_no_early_lv", 32'(lv_seen), 0);
    step();                                  // edge 7
    check("simul_lv0", 32'(load_valid), 1);
    check("simul_idx0", 32'(load_idx), 0);
    check("simul_val0", 32'(load_value), 5);
    step();                                  // edge 8
    check("simul_lv1", 32'(load_valid), 1);
    check("simul_idx1", 32'(load_idx), 3);
    check("simul_val1", 32'(load_value), 5);
    step();                                  // edge 9
    check("simul_end", 32'(load_valid), 0);
    check("simul_guess", 32'(guess_count), 3);
    button = 4'h0;
    repeat (10) step();

    // Reset while button 1 is still debouncing.
    button = 4'b0010;
    repeat (4) step();                       // now just after edge 3
    rst_n = 1'b0;
    step();
    step();
    button = 4'h0;
    step();
    rst_n = 1'b1;
    lv_seen = 0;
    repeat (20) begin
      step();
      lv_seen += int'(load_valid);
    end
    check("midrst_no_load", 32'(lv_seen), 0);
    check("midrst_level", 32'(btn_level), 0);
    check("midrst_guess", 32'(guess_count), 0);

    // Saturation: 260 presses on button 0.
    bcd   = 4'd3;
    bad   = 0;
    total = 0;
    for (int p = 1; p <= 260; p++) begin
      button  = 4'b0001;
      lv_seen = 0;
      repeat (10) begin
        step();
        if (load_valid) begin
          lv_seen++;
          if (load_idx != 2'd0 || load_value != 4'd3) bad++;
        end
      end
      button = 4'b0000;
      repeat (10) begin
        step();
        if (load_valid) lv_seen++;
      end
      if (lv_seen != 1) bad++;
      total += lv_seen;
      if (p == 254) check("sat_guess254", 32'(guess_count), 254);
      if (p == 255) check("sat_guess255", 32'(guess_count), 255);
    end
    check("sat_pulses_ok", 32'(bad), 0);
    check("sat_total_pulses", 32'(total), 260);
    check("sat_guess_hold", 32'(guess_count), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
